// File: rtl/bill_pkg.sv
// Shared types and default widths for the bill running-total engine.
package bill_pkg;

    typedef enum logic {
        IDLE = 1'b0,
        ADD  = 1'b1
    } state_t;

    localparam int DEF_WIDTH     = 12;
    localparam int DEF_ACC_WIDTH = 16;
    localparam int DEF_CHUNK     = 4;
    localparam int DEF_CNT_WIDTH = 8;

    function automatic int nchunk(input int acc_width, input int chunk);
        return acc_width / chunk;
    endfunction

endpackage

// File: rtl/bill_accumulator_if.sv
// Item-amount handshake between the bill generator and the accumulator.
interface bill_accumulator_if #(
    parameter int WIDTH = bill_pkg::DEF_WIDTH
);
    logic             in_valid;
    logic             in_ready;
    logic [WIDTH-1:0] in_amount;

    modport master (output in_valid, output in_amount, input  in_ready);
    modport slave  (input  in_valid, input  in_amount, output in_ready);
endinterface

// File: rtl/bill_chunk_add.sv
// CHUNK-bit ripple adder with carry in/out, built from fa cells; purely combinational.
module bill_chunk_add #(
    parameter int CHUNK = bill_pkg::DEF_CHUNK
) (
    input  logic [CHUNK-1:0] a,
    input  logic [CHUNK-1:0] b,
    input  logic             cin,
    output logic [CHUNK-1:0] sum,
    output logic             cout
);
    logic [CHUNK:0] c;

    assign c[0] = cin;

    for (genvar i = 0; i < CHUNK; i++) begin : g_bit
        fa u_fa (
            .a  (a[i]),
            .b  (b[i]),
            .ci (c[i]),
            .s  (sum[i]),
            .co (c[i+1])
        );
    end

    assign cout = c[CHUNK];
endmodule

// File: rtl/fa.sv
// Single-bit full adder cell.
module fa (
    input  logic a,
    input  logic b,
    input  logic ci,
    output logic s,
    output logic co
);
    assign s  = a ^ b ^ ci;
    assign co = (a & b) | (ci & (a ^ b));
endmodule

// File: rtl/bill_accumulator.sv
// Running-total engine: adds each accepted amount CHUNK bits per clock, commits after NCHUNK cycles.
// Optional BILL_ACC_SATURATE_EN clamps the total at all-ones on carry-out instead of wrapping.
module bill_accumulator
    import bill_pkg::*;
#(
    parameter int WIDTH     = DEF_WIDTH,
    parameter int ACC_WIDTH = DEF_ACC_WIDTH,
    parameter int CHUNK     = DEF_CHUNK,
    parameter int CNT_WIDTH = DEF_CNT_WIDTH
) (
    input  logic                 clk,
    input  logic                 rst_n,
    input  logic                 clear,
    bill_accumulator_if.slave    in_if,
    output logic [ACC_WIDTH-1:0] total,
    output logic                 total_valid,
    output logic [CNT_WIDTH-1:0] item_count,
    output logic                 overflow,
    output logic                 busy
);
    localparam int NCHUNK = nchunk(ACC_WIDTH, CHUNK);
    localparam int IDX_W  = (NCHUNK > 1) ? $clog2(NCHUNK) : 1;
    localparam logic [IDX_W-1:0] LAST_IDX = IDX_W'(NCHUNK - 1);

    state_t                 state, state_nxt;
    logic [ACC_WIDTH-1:0]   operand;
    logic [ACC_WIDTH-1:0]   work;
    logic [ACC_WIDTH-1:0]   work_sum;
    logic [ACC_WIDTH-1:0]   commit_val;
    logic                   carry;
    logic [IDX_W-1:0]       idx;
    logic                   accept;
    logic                   last;
    logic [CHUNK-1:0]       chunk_sum;
    logic                   chunk_cout;

    assign in_if.in_ready = (state == IDLE) && !clear;
    assign accept         = in_if.in_valid && in_if.in_ready;
    assign busy           = (state == ADD);
    assign last           = (idx == LAST_IDX);

    bill_chunk_add #(.CHUNK(CHUNK)) u_chunk_add (
        .a    (work[idx*CHUNK +: CHUNK]),
        .b    (operand[idx*CHUNK +: CHUNK]),
        .cin  (carry),
        .sum  (chunk_sum),
        .cout (chunk_cout)
    );

    // Full result as it will look once the final chunk lands; only used at commit.
    always_comb begin
        work_sum = work;
        work_sum[idx*CHUNK +: CHUNK] = chunk_sum;
    end

`ifdef BILL_ACC_SATURATE_EN
    assign commit_val = chunk_cout ? '1 : work_sum;
`else
    assign commit_val = work_sum;
`endif

    always_ff @(posedge clk or negedge rst_n) begin
        if (!rst_n) state <= IDLE;
        else        state <= state_nxt;
    end

    always_comb begin
        state_nxt = state;
        case (state)
            IDLE:    if (accept) state_nxt = ADD;
            ADD:     if (clear || last) state_nxt = IDLE;
            default: state_nxt = IDLE;
        endcase
    end

    always_ff @(posedge clk or negedge rst_n) begin
        if (!rst_n) begin
            operand     <= '0;
            work        <= '0;
            carry       <= 1'b0;
            idx         <= '0;
            total       <= '0;
            total_valid <= 1'b0;
            item_count  <= '0;
            overflow    <= 1'b0;
        end else begin
            total_valid <= 1'b0;
            if (clear) begin
                total      <= '0;
                item_count <= '0;
                overflow   <= 1'b0;
            end else if (state == IDLE) begin
                if (accept) begin
                    operand <= ACC_WIDTH'(in_if.in_amount);
                    work    <= total;
                    carry   <= 1'b0;
                    idx     <= '0;
                    if (item_count != '1) item_count <= item_count + 1'b1;
                end
            end else begin
                work[idx*CHUNK +: CHUNK] <= chunk_sum;
                carry <= chunk_cout;
                idx   <= idx + 1'b1;
                if (last) begin
                    total       <= commit_val;
                    total_valid <= 1'b1;
                    overflow    <= overflow | chunk_cout;
                end
            end
        end
    end
endmodule
